// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the write-back path: datapath widths, buffer depth,
// the write-back request record and the write-port source selector.
// -----------------------------------------------------------------------------
package rv_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned REG_ADDR_W    = 5;
   localparam int unsigned WB_FIFO_DEPTH = 2;
   localparam int unsigned NUM_REGS      = 1 << REG_ADDR_W;

   // One register-file write: destination register and value.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Which source drives the write port in a given cycle.
   typedef enum logic [1:0] {
      WB_SRC_NONE   = 2'd0,
      WB_SRC_ALU    = 2'd1,
      WB_SRC_FIFO   = 2'd2,
      WB_SRC_BYPASS = 2'd3
   } wb_src_e;

   // x0 is hard-wired to zero and never written or tracked.
   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
      return addr == '0;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small show-ahead FIFO of write-back requests. The head entry is visible
// combinationally whenever the FIFO is non-empty; pop consumes it.
// Push and pop may happen in the same cycle. A push while full or a pop
// while empty is ignored, so entries are never overwritten or reordered.
//
// Ports
//   clk        in   clock (rising edge)
//   rst_n      in   synchronous active-low reset, empties the FIFO
//   push       in   write push_data at the tail
//   push_data  in   request to store
//   pop        in   discard the head entry
//   head       out  oldest entry (valid while empty=0)
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
// -----------------------------------------------------------------------------
module wb_fifo
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wb_req_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   // Pointers wrap explicitly so non-power-of-two depths also work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1))
         return '0;
      return ptr + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been pushed.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rf_wb_ctrl.sv
// -----------------------------------------------------------------------------
// rf_wb_ctrl
// Register-file write-back arbiter with a pending-write scoreboard.
// The ALU result always wins the single write port. LSU results are
// handshaked into a small FIFO and drained in order whenever the ALU is
// idle; with the FIFO empty an accepted LSU result bypasses straight to
// the port. Writes to x0 are dropped but still consume their source.
// A per-register pending bit is set when a long-latency op issues and
// cleared once its LSU write has been presented on the write port.
//
// Ports
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_alu_valid/i_alu_rd/i_alu_data    single-cycle ALU result, no stall
//   i_lsu_valid/i_lsu_rd/i_lsu_data    LSU result, accepted when o_lsu_ready
//   o_lsu_ready                        FIFO has room
//   i_issue_valid/i_issue_rd           long-latency op issued, rd pending
//   i_rs1_addr/i_rs2_addr              operand addresses to check
//   o_rs1_busy/o_rs2_busy              operand has a pending write
//   o_rd_wren/o_rd_addr/o_rd_data      registered register-file write port
// -----------------------------------------------------------------------------
module rf_wb_ctrl
   import rv_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_alu_valid,
   input  logic [REG_ADDR_W-1:0] i_alu_rd,
   input  logic [XLEN-1:0]       i_alu_data,
   input  logic                  i_lsu_valid,
   input  logic [REG_ADDR_W-1:0] i_lsu_rd,
   input  logic [XLEN-1:0]       i_lsu_data,
   output logic                  o_lsu_ready,
   input  logic                  i_issue_valid,
   input  logic [REG_ADDR_W-1:0] i_issue_rd,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   output logic                  o_rs1_busy,
   output logic                  o_rs2_busy,
   output logic                  o_rd_wren,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic [XLEN-1:0]       o_rd_data
);

   wb_req_t               fifo_head;
   wb_req_t               lsu_req;
   wb_req_t               sel;
   wb_src_e               src;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  lsu_fire;
   logic                  wr_en;
   logic                  wr_from_lsu;
   logic                  rd_is_lsu;
   logic [NUM_REGS-1:0]   pending;
   logic [NUM_REGS-1:0]   pending_nxt;

   assign lsu_req = '{rd: i_lsu_rd, data: i_lsu_data};

   // Ready depends only on the registered fill level (and reset), never on
   // this cycle's valids, so a full FIFO refuses even when it is popping.
   assign o_lsu_ready = i_rst_n & ~fifo_full;
   assign lsu_fire    = i_lsu_valid & o_lsu_ready;

   wb_fifo #(
      .DEPTH (WB_FIFO_DEPTH)
   ) u_wb_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (fifo_push),
      .push_data (lsu_req),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Source selection. Buffered entries are older than a new LSU result, so
   // the new result is only bypassed when nothing is waiting in the FIFO.
   always_comb begin
      src       = WB_SRC_NONE;
      sel       = '0;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      if (i_alu_valid) begin
         src       = WB_SRC_ALU;
         sel       = '{rd: i_alu_rd, data: i_alu_data};
         fifo_push = lsu_fire;
      end else if (!fifo_empty) begin
         src       = WB_SRC_FIFO;
         sel       = fifo_head;
         fifo_pop  = 1'b1;
         fifo_push = lsu_fire;
      end else if (lsu_fire) begin
         src       = WB_SRC_BYPASS;
         sel       = lsu_req;
      end
   end

   assign wr_en       = (src != WB_SRC_NONE) && !is_x0(sel.rd);
   assign wr_from_lsu = (src == WB_SRC_FIFO) || (src == WB_SRC_BYPASS);

   // Address and data only move on a real write so they hold otherwise.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_rd_wren <= 1'b0;
         o_rd_addr <= '0;
         o_rd_data <= '0;
         rd_is_lsu <= 1'b0;
      end else begin
         o_rd_wren <= wr_en;
         rd_is_lsu <= wr_en & wr_from_lsu;
         if (wr_en) begin
            o_rd_addr <= sel.rd;
            o_rd_data <= sel.data;
         end
      end
   end

   // Clear is taken from the registered port so the bit drops only after the
   // write is visible; a same-cycle issue to that rd is applied last and wins.
   always_comb begin
      pending_nxt = pending;
      if (rd_is_lsu)
         pending_nxt[o_rd_addr] = 1'b0;
      if (i_issue_valid && !is_x0(i_issue_rd))
         pending_nxt[i_issue_rd] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   assign o_rs1_busy = !is_x0(i_rs1_addr) && pending[i_rs1_addr];
   assign o_rs2_busy = !is_x0(i_rs2_addr) && pending[i_rs2_addr];

endmodule
